// File: rtl/par_in_pkg.sv
// Shared defaults, count-width helper and push-side parity check for par_in_fifo.
// The parity helper is only referenced when PAR_IN_PARITY_EN is defined.
package par_in_pkg;

  localparam int PAR_IN_WIDTH_DEF = 8;
  localparam int PAR_IN_DEPTH_DEF = 4;
  localparam int PAR_IN_MAX_W     = 64;

  function automatic int par_in_cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

  // Odd parity over {data, par}; returns 1 when the word arrived with a parity error.
  // Narrower data is zero-extended by the caller, which leaves the XOR unchanged.
  function automatic logic par_in_perr(input logic [PAR_IN_MAX_W-1:0] data, input logic par);
    return ~((^data) ^ par);
  endfunction

endpackage

// File: rtl/par_in_mem.sv
// Unreset DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
module par_in_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  // Write port; contents are only ever read back after being written.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/par_in_fifo.sv
// Parallel input port: valid/ready capture into a DEPTH-entry FIFO with occupancy count.
// Optional odd-parity checking on push is enabled by defining PAR_IN_PARITY_EN.
module par_in_fifo
  import par_in_pkg::*;
#(
  parameter int WIDTH = PAR_IN_WIDTH_DEF,
  parameter int DEPTH = PAR_IN_DEPTH_DEF
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               din,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               dout,
`ifdef PAR_IN_PARITY_EN
  input  logic                           din_par,
  output logic                           dout_perr,
  output logic                           perr_sticky,
`endif
  output logic [par_in_cnt_w(DEPTH)-1:0] count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = par_in_cnt_w(DEPTH);
`ifdef PAR_IN_PARITY_EN
  localparam int MW = WIDTH + 1;
`else
  localparam int MW = WIDTH;
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push;
  logic          pop;
  logic          full;
  logic [MW-1:0] mem_wdata;
  logic [MW-1:0] mem_rdata;

  // in_ready comes from the registered count, so a pop on a full FIFO frees space only next cycle.
  assign full      = (count_q == CW'(DEPTH));
  assign in_ready  = ~full & ~rst;
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

`ifdef PAR_IN_PARITY_EN
  logic push_perr;
  logic perr_sticky_q, perr_sticky_d;

  assign push_perr   = par_in_perr(PAR_IN_MAX_W'(din), din_par);
  assign mem_wdata   = {push_perr, din};
  assign perr_sticky = perr_sticky_q;

  // Sticky error flag and head-entry error output.
  always_comb begin
    perr_sticky_d = perr_sticky_q;
    if (push && push_perr) begin
      perr_sticky_d = 1'b1;
    end else begin
      perr_sticky_d = perr_sticky_q;
    end
    if (out_valid) begin
      dout_perr = mem_rdata[WIDTH];
    end else begin
      dout_perr = 1'b0;
    end
  end

  // Sticky flag register, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      perr_sticky_q <= 1'b0;
    end else begin
      perr_sticky_q <= perr_sticky_d;
    end
  end
`else
  assign mem_wdata = din;
`endif

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Control registers; reset discards all stored words.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Head word is masked to zero while empty so stale storage never leaks out.
  always_comb begin
    if (out_valid) begin
      dout = mem_rdata[WIDTH-1:0];
    end else begin
      dout = '0;
    end
  end

  par_in_mem #(
    .WIDTH (MW),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q),
    .wdata (mem_wdata),
    .raddr (rd_ptr_q),
    .rdata (mem_rdata)
  );

endmodule

// File: tb/tb_par_in_fifo.sv
// Self-checking bench for par_in_fifo: directed steps plus random traffic against a queue model.
module tb_par_in_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] din;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic [CW-1:0]    count;
`ifdef PAR_IN_PARITY_EN
  logic             din_par;
  logic             dout_perr;
  logic             perr_sticky;
`endif

  int n_chk = 0;
  int n_err = 0;

  // Model: each entry is {parity_error, data}.
  logic [WIDTH:0] mq[$];
  logic           m_sticky = 1'b0;

  always #5 clk = ~clk;

  par_in_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .din         (din),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .dout        (dout),
`ifdef PAR_IN_PARITY_EN
    .din_par     (din_par),
    .dout_perr   (dout_perr),
    .perr_sticky (perr_sticky),
`endif
    .count       (count)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive a word with correct (odd) parity unless bad is set.
  task automatic drive(input logic v, input logic [WIDTH-1:0] d, input logic bad);
    in_valid = v;
    din      = d;
`ifdef PAR_IN_PARITY_EN
    din_par  = bad ? (^d) : ~(^d);
`else
    if (bad) begin end
`endif
  endtask

  // One cycle: compare outputs with the model at negedge, advance the model, pass the edge.
  task automatic tick();
    logic exp_rdy;
    logic exp_ov;
    logic err;
    @(negedge clk);
    exp_rdy = (mq.size() < DEPTH) && !rst;
    exp_ov  = (mq.size() != 0);
    check("in_ready", 32'(in_ready), 32'(exp_rdy));
    check("out_valid", 32'(out_valid), 32'(exp_ov));
    check("count", 32'(count), 32'(mq.size()));
    check("dout", 32'(dout), exp_ov ? 32'(mq[0][WIDTH-1:0]) : 32'd0);
`ifdef PAR_IN_PARITY_EN
    check("dout_perr", 32'(dout_perr), exp_ov ? 32'(mq[0][WIDTH]) : 32'd0);
    check("perr_sticky", 32'(perr_sticky), 32'(m_sticky));
    err = ~(^{din, din_par});
`else
    err = 1'b0;
`endif
    if (rst) begin
      mq.delete();
      m_sticky = 1'b0;
    end else begin
      if (exp_ov && out_ready) void'(mq.pop_front());
      if (in_valid && exp_rdy) begin
        mq.push_back({err, din});
        if (err) m_sticky = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst       = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    @(posedge clk);
    #1;

    // Reset held, then released.
    tick();
    tick();
    rst = 1'b0;
    tick();
    check("idle_ready", 32'(in_ready), 32'd1);

    // Single word.
    drive(1'b1, 8'hA5, 1'b0);
    tick();
    drive(1'b0, 8'h00, 1'b0);
    check("single_dout", 32'(dout), 32'h0A5);
    check("single_count", 32'(count), 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("single_empty", 32'(out_valid), 32'd0);
    tick();

    // Fill to full, fifth word held off.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 8'(i), 1'b0);
      tick();
    end
    drive(1'b1, 8'h05, 1'b0);
    tick();
    check("full_count", 32'(count), 32'd4);
    check("full_ready", 32'(in_ready), 32'd0);

    // Pop on full: no push that cycle, push accepted next cycle.
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("fullpop_count", 32'(count), 32'd3);
    check("fullpop_ready", 32'(in_ready), 32'd1);
    tick();
    check("refill_count", 32'(count), 32'd4);
    drive(1'b0, 8'h00, 1'b0);
    out_ready = 1'b1;
    for (int i = 2; i <= 5; i++) begin
      check("drain_dout", 32'(dout), 32'(i));
      tick();
    end
    out_ready = 1'b0;

    // Steady-state streaming at count=2 with pointer wrap.
    drive(1'b1, 8'(($urandom)), 1'b0);
    tick();
    drive(1'b1, 8'(($urandom)), 1'b0);
    tick();
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(1'b1, 8'(($urandom)), 1'b0);
      tick();
      check("stream_count", 32'(count), 32'd2);
    end
    drive(1'b0, 8'h00, 1'b0);
    out_ready = 1'b0;

    // Parity error on push, then reset mid-stream at count=3.
    drive(1'b1, 8'h03, 1'b1);
    tick();
`ifdef PAR_IN_PARITY_EN
    check("sticky_set", 32'(perr_sticky), 32'd1);
`endif
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0);
    tick();
    tick();
    out_ready = 1'b0;
`ifdef PAR_IN_PARITY_EN
    check("perr_head", 32'(dout_perr), 32'd1);
`endif
    check("head_03", 32'(dout), 32'h03);
    drive(1'b1, 8'h11, 1'b0);
    tick();
    drive(1'b1, 8'h22, 1'b0);
    tick();
    check("pre_rst_count", 32'(count), 32'd3);
    rst = 1'b1;
    out_ready = 1'b1;
    tick();
    rst = 1'b0;
    out_ready = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_valid", 32'(out_valid), 32'd0);
`ifdef PAR_IN_PARITY_EN
    check("rst_sticky", 32'(perr_sticky), 32'd0);
`endif
    tick();

    // Random traffic with occasional parity errors and resets.
    for (int i = 0; i < 300; i++) begin
      drive(1'($urandom_range(0, 2) != 0), 8'($urandom), 1'($urandom_range(0, 9) == 0));
      out_ready = 1'($urandom_range(0, 2) != 0);
      rst       = 1'($urandom_range(0, 49) == 0);
      tick();
    end
    rst = 1'b0;
    drive(1'b0, 8'h00, 1'b0);
    out_ready = 1'b1;
    for (int i = 0; i < DEPTH + 1; i++) tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
